mux_config_loader: RTL and testbench

MUX_CONFIG_LOADER -- requirements
Module: mux_config_loader

---
 rtl/mux_config_pkg.sv | 17 +
 rtl/mux_config_loader_if.sv | 24 ++
 rtl/sel_shadow_reg.sv | 31 +++
 rtl/mux_config_loader.sv | 120 ++++++++++++
 tb/tb_mux_config_loader.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_config_pkg.sv
// Shared types and helpers for the serial mux-select configuration loader.
package mux_config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int DEFAULT_NSEL = 16;

  // One frame is NSEL data bits followed by a single even-parity bit.
  function automatic int frame_len(input int nsel);
    return nsel + 1;
  endfunction

endpackage

// File: rtl/mux_config_loader_if.sv
// Serial configuration port and applied select vector of the loader.
interface mux_config_loader_if #(
  parameter int NSEL = 16
);
  logic            start;
  logic            abort;
  logic            din;
  logic            din_valid;
  logic            din_ready;
  logic [NSEL-1:0] msel;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output start, abort, din, din_valid,
    input  din_ready, msel, busy, done, err
  );

  modport slave (
    input  start, abort, din, din_valid,
    output din_ready, msel, busy, done, err
  );
endinterface

// File: rtl/sel_shadow_reg.sv
// Shadow select register filled one bit at a time, with serially accumulated parity.
module sel_shadow_reg #(
  parameter int NSEL = 16,
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [IDXW-1:0] idx,
  input  logic            bit_in,
  output logic [NSEL-1:0] shadow,
  output logic            parity
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      shadow <= '0;
      parity <= 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < NSEL; i++) begin
        if (idx == IDXW'(i)) shadow[i] <= bit_in;
      end
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/mux_config_loader.sv
// Loads a serial frame of mux select bits and applies it only after parity passes.
//   state    | meaning
//   ST_IDLE  | waiting for start; msel holds last good frame
//   ST_SHIFT | accepting data bits, then the parity bit
//   ST_CHECK | one cycle: apply shadow or flag parity error
module mux_config_loader
  import mux_config_pkg::*;
#(
  parameter int              NSEL      = 16,
  parameter logic [NSEL-1:0] RESET_SEL = '0
) (
  input logic               clk,
  input logic               rst,
  mux_config_loader_if.slave bus
);

  localparam int            FRAME_LEN = frame_len(NSEL);
  localparam int            CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NSEL);

  state_t          state;
  logic [CW-1:0]   count;
  logic            parity_bit;
  logic [NSEL-1:0] msel_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic            ready;
  logic            accept;
  logic            shadow_wr;
  logic            shadow_clear;
  logic [NSEL-1:0] shadow;
  logic            parity_acc;

  assign ready        = (state == ST_SHIFT) & ~bus.abort;
  assign accept       = bus.din_valid & ready;
  assign shadow_wr    = accept & (count != LAST_IDX);
  // Shadow is wiped both when a frame opens and when one is abandoned.
  assign shadow_clear = ((state == ST_IDLE) & bus.start & ~bus.abort) |
                        ((state != ST_IDLE) & bus.abort);

  assign bus.din_ready = ready;
  assign bus.msel      = msel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  sel_shadow_reg #(
    .NSEL (NSEL),
    .IDXW (CW)
  ) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .clear  (shadow_clear),
    .wr_en  (shadow_wr),
    .idx    (count),
    .bit_in (bus.din),
    .shadow (shadow),
    .parity (parity_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      parity_bit <= 1'b0;
      msel_q     <= RESET_SEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start & ~bus.abort) begin
            state  <= ST_SHIFT;
            count  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            count  <= '0;
            busy_q <= 1'b0;
          end else if (accept) begin
            if (count == LAST_IDX) begin
              parity_bit <= bus.din;
              state      <= ST_CHECK;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          state  <= ST_IDLE;
          count  <= '0;
          busy_q <= 1'b0;
          // Even parity: data XOR parity bit must come out zero.
          if (!bus.abort) begin
            if ((parity_acc ^ parity_bit) == 1'b0) begin
              msel_q <= shadow;
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          count  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_config_loader.sv
// Directed bench for mux_config_loader with NSEL=4, RESET_SEL=0.
module tb_mux_config_loader;

  logic clk;
  logic rst;

  mux_config_loader_if #(.NSEL(4)) bus ();

  mux_config_loader #(
    .NSEL      (4),
    .RESET_SEL (4'b0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic       din;
    logic       din_valid;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
    logic [3:0] exp_msel;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  function automatic vec_t mk(input logic s, input logic a, input logic d, input logic v,
                              input logic rdy, input logic b, input logic dn, input logic e,
                              input logic [3:0] m);
    vec_t r;
    r.start = s; r.abort = a; r.din = d; r.din_valid = v;
    r.exp_ready = rdy; r.exp_busy = b; r.exp_done = dn; r.exp_err = e; r.exp_msel = m;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic a, input logic d, input logic v);
    bus.start = s; bus.abort = a; bus.din = d; bus.din_valid = v;
  endtask

  // {busy, done, err, msel} packed for compact comparison
  function automatic logic [6:0] outs();
    return {bus.busy, bus.done, bus.err, bus.msel};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] frame;
    n_pass  = 0;
    n_total = 0;

    // good frame 1,0,1,1 p=1
    vecs.push_back(mk(1,0,0,0, 0,1,0,0,4'h0));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'h0));
    vecs.push_back(mk(0,0,0,1, 1,1,0,0,4'h0));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'h0));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'h0));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'h0));
    vecs.push_back(mk(0,0,0,0, 0,0,1,0,4'hD));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,4'hD));
    // same data, bad parity
    vecs.push_back(mk(1,0,0,0, 0,1,0,0,4'hD));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,0,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,0,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,0,0, 0,0,0,1,4'hD));
    vecs.push_back(mk(0,0,0,0, 0,0,0,1,4'hD));
    // start clears err; two bits then abort alongside a valid bit
    vecs.push_back(mk(1,0,0,0, 0,1,0,0,4'hD));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,1,0,1, 0,0,0,0,4'hD));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,4'hD));
    // good frame 0,1,0,0 p=1 -> 4'b0010
    vecs.push_back(mk(1,0,0,0, 0,1,0,0,4'hD));
    vecs.push_back(mk(0,0,0,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,0,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,0,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'hD));
    vecs.push_back(mk(0,0,0,0, 0,0,1,0,4'h2));
    // good frame 1,1,1,1 p=0 aborted in CHECK
    vecs.push_back(mk(1,0,0,0, 0,1,0,0,4'h2));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'h2));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'h2));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'h2));
    vecs.push_back(mk(0,0,1,1, 1,1,0,0,4'h2));
    vecs.push_back(mk(0,0,0,1, 1,1,0,0,4'h2));
    vecs.push_back(mk(0,1,0,0, 0,0,0,0,4'h2));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,4'h2));
    // start with abort in IDLE does not open a frame
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,4'h2));
    vecs.push_back(mk(0,0,1,1, 0,0,0,0,4'h2));

    // reset
    rst = 1'b1;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("in_reset_outs", outs(), 7'b000_0000);
    check("in_reset_ready", bus.din_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_release_outs", outs(), 7'b000_0000);
    check("reset_release_ready", bus.din_ready, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].abort, vecs[i].din, vecs[i].din_valid);
      #1;
      check($sformatf("row%0d_ready", i), bus.din_ready, vecs[i].exp_ready);
      tick();
      check($sformatf("row%0d_outs", i), outs(),
            {vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_msel});
    end

    // gapped frame 1,0,1,1 p=1 with a stray start mid-frame
    frame = 5'b11101;
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    check("gap_start_busy", outs(), 7'b100_0010);
    for (int k = 0; k < 5; k++) begin
      for (int g = 0; g < 5; g++) begin
        drive((k == 2 && g == 2), 0, ~frame[k], 0);
        tick();
        check($sformatf("gap_hold_b%0d_g%0d", k, g), outs(), 7'b100_0010);
      end
      drive(0, 0, frame[k], 1);
      tick();
      drive(0, 0, 0, 0);
      check($sformatf("gap_accept_b%0d", k), outs(), 7'b100_0010);
    end
    tick();
    check("gap_apply", outs(), 7'b010_1101);
    tick();
    check("gap_done_drop", outs(), 7'b000_1101);

    // asynchronous reset mid-frame
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 1);
    tick();
    tick();
    drive(0, 0, 0, 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outs", outs(), 7'b000_0000);
    check("async_rst_ready", bus.din_ready, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 1);
      #1;
      check($sformatf("post_rst_ready%0d", k), bus.din_ready, 1'b0);
      tick();
      check($sformatf("post_rst_outs%0d", k), outs(), 7'b000_0000);
    end

    // fresh frame 0,1,1,1 p=1 -> 4'b1110
    frame = 5'b11110;
    drive(1, 0, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, frame[k], 1);
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    check("post_rst_frame", outs(), 7'b010_1110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
